// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg - shared definitions for the pipeline stage registers.
//
// Contents:
//   * default widths for data, register index and write-back control
//   * write-back control bit positions (RegWrite, MemtoReg)
//   * mem_wb_t: MEM/WB payload layout at the default widths
//
// Configuration macro used by users of this package: MEM_WB_FWD_EN
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int WB_W_DEF   = 2;

  // Bit positions inside the write-back control field.
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Payload order, MSB first: read data, ALU result, destination, control.
  // Parametrised stages use the same field order at their own widths.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] read_data;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [REG_AW_DEF-1:0] write_register;
    logic [WB_W_DEF-1:0]   wb;
  } mem_wb_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf - two-entry valid/ready skid buffer, generic payload.
//
// Entry M drives the output; entry S absorbs one word when the consumer
// stalls. o_ready is a flop output (no i_ready -> o_ready path).
//
// Ports:
//   i_clk    rising-edge clock
//   i_srst   synchronous active-high reset (clears valids and payload)
//   i_flush  drop both entries at the edge; any accept that cycle is lost
//   i_valid  upstream word present       o_ready  can accept (registered)
//   i_data   upstream payload
//   o_valid  M holds a word               i_ready  downstream consumes
//   o_data   M payload (held after M empties)
// ---------------------------------------------------------------------------
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_srst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_m_valid;
  logic         r_s_valid;
  logic         r_ready;
  logic [W-1:0] r_m_data;
  logic [W-1:0] r_s_data;

  logic         w_accept;
  logic         w_pop;
  logic         w_m_valid_next;
  logic         w_s_valid_next;
  logic [W-1:0] w_m_data_next;
  logic [W-1:0] w_s_data_next;

  assign w_accept = i_valid & r_ready;
  assign w_pop    = r_m_valid & i_ready;

  always_comb begin
    w_m_valid_next = r_m_valid;
    w_s_valid_next = r_s_valid;
    w_m_data_next  = r_m_data;
    w_s_data_next  = r_s_data;
    if (i_flush) begin
      // Payload is left alone; only the valid bits are dropped.
      w_m_valid_next = 1'b0;
      w_s_valid_next = 1'b0;
    end else if (w_pop) begin
      if (r_s_valid) begin
        // r_ready is low while S is valid, so no accept can collide here.
        w_m_data_next  = r_s_data;
        w_s_valid_next = 1'b0;
      end else if (w_accept) begin
        w_m_data_next = i_data;
      end else begin
        w_m_valid_next = 1'b0;
      end
    end else if (w_accept) begin
      if (r_m_valid) begin
        w_s_valid_next = 1'b1;
        w_s_data_next  = i_data;
      end else begin
        w_m_valid_next = 1'b1;
        w_m_data_next  = i_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_ready   <= 1'b1;
      r_m_data  <= '0;
      r_s_data  <= '0;
    end else begin
      r_m_valid <= w_m_valid_next;
      r_s_valid <= w_s_valid_next;
      r_ready   <= !w_s_valid_next;
      r_m_data  <= w_m_data_next;
      r_s_data  <= w_s_data_next;
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_m_valid;
  assign o_data  = r_m_data;

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage - MEM/WB pipeline register with valid/ready handshake,
// two-entry skid buffer, synchronous flush and write-back forwarding.
//
// Ports:
//   clock, startin (sync active-high reset), flush
//   in_valid / in_ready (registered), read_data_input, alu_result_input,
//   write_register_input, WB_input
//   out_valid / out_ready, read_data_output, alu_result_output,
//   write_register_output, WB_output (forced to 0 while out_valid=0)
//   fwd_valid, fwd_reg, fwd_data (combinational from the output entry only)
//
// Configuration: define MEM_WB_FWD_EN to enable the forwarding port;
// otherwise the fwd_* outputs are constant 0. WB_W must be at least 2.
// ---------------------------------------------------------------------------
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int WB_W   = WB_W_DEF
) (
  input  logic              clock,
  input  logic              startin,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] read_data_input,
  input  logic [DATA_W-1:0] alu_result_input,
  input  logic [REG_AW-1:0] write_register_input,
  input  logic [WB_W-1:0]   WB_input,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] read_data_output,
  output logic [DATA_W-1:0] alu_result_output,
  output logic [REG_AW-1:0] write_register_output,
  output logic [WB_W-1:0]   WB_output,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data
);

  // Same field order as pipe_pkg::mem_wb_t, sized by this instance.
  typedef struct packed {
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_AW-1:0] write_register;
    logic [WB_W-1:0]   wb;
  } stage_word_t;

  stage_word_t w_in_word;
  stage_word_t w_out_word;

  assign w_in_word = '{read_data:      read_data_input,
                       alu_result:     alu_result_input,
                       write_register: write_register_input,
                       wb:             WB_input};

  pipe_skid_buf #(
    .W($bits(stage_word_t))
  ) u_skid (
    .i_clk   (clock),
    .i_srst  (startin),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_word),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_out_word)
  );

  assign read_data_output      = w_out_word.read_data;
  assign alu_result_output     = w_out_word.alu_result;
  assign write_register_output = w_out_word.write_register;
  // A held-but-invalid entry must never look like a register write.
  assign WB_output             = out_valid ? w_out_word.wb : '0;

`ifdef MEM_WB_FWD_EN
  // Register 0 is hard-wired zero, so writes to it are never forwarded.
  assign fwd_valid = out_valid & WB_output[WB_REGWRITE] &
                     (write_register_output != '0);
  assign fwd_reg   = write_register_output;
  assign fwd_data  = WB_output[WB_MEMTOREG] ? read_data_output : alu_result_output;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage - self-checking bench for mem_wb_stage.
// A two-deep FIFO model supplies expected outputs; stimulus tables cover
// streaming and stall/release, hand sequences cover flush, reset mid-stall,
// forwarding and bubbles. Honours MEM_WB_FWD_EN.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  rg;
    logic [1:0]  wb;
  } word_t;

  typedef struct {
    logic  iv;
    logic  ordy;
    word_t w;
    logic  exp_ov;
    logic  exp_ir;
  } vec_t;

  logic        clock;
  logic        startin;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] read_data_output;
  logic [31:0] alu_result_output;
  logic [4:0]  write_register_output;
  logic [1:0]  WB_output;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  word_t       cur_w;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5), .WB_W(2)) dut (
    .clock                 (clock),
    .startin               (startin),
    .flush                 (flush),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .read_data_input       (cur_w.rd),
    .alu_result_input      (cur_w.alu),
    .write_register_input  (cur_w.rg),
    .WB_input              (cur_w.wb),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .read_data_output      (read_data_output),
    .alu_result_output     (alu_result_output),
    .write_register_output (write_register_output),
    .WB_output             (WB_output),
    .fwd_valid             (fwd_valid),
    .fwd_reg               (fwd_reg),
    .fwd_data              (fwd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    n_pass  = 0;
  int    n_total = 0;
  word_t q[$];          // scoreboard: words accepted but not yet consumed
  word_t held;          // payload the output entry should be showing
  vec_t  vecs[14];

  function automatic word_t mk(input logic [31:0] alu, input logic [4:0] rg,
                               input logic [1:0] wb, input logic [31:0] rd);
    word_t w;
    w.rd  = rd;
    w.alu = alu;
    w.rg  = rg;
    w.wb  = wb;
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Compare every DUT output against the scoreboard state.
  task automatic check_outputs();
    logic        e_ov;
    logic        e_ir;
    logic [1:0]  e_wb;
    logic        e_fv;
    logic [4:0]  e_fr;
    logic [31:0] e_fd;
    e_ov = (q.size() != 0);
    e_ir = (q.size() < 2);
    e_wb = e_ov ? held.wb : 2'b00;
`ifdef MEM_WB_FWD_EN
    e_fv = e_ov & e_wb[1] & (held.rg != 5'd0);
    e_fr = held.rg;
    e_fd = e_wb[0] ? held.rd : held.alu;
`else
    e_fv = 1'b0;
    e_fr = 5'd0;
    e_fd = 32'd0;
`endif
    chk("in_ready",   64'(in_ready),              64'(e_ir));
    chk("out_valid",  64'(out_valid),             64'(e_ov));
    chk("WB_output",  64'(WB_output),             64'(e_wb));
    chk("read_data",  64'(read_data_output),      64'(held.rd));
    chk("alu_result", 64'(alu_result_output),     64'(held.alu));
    chk("write_reg",  64'(write_register_output), 64'(held.rg));
    chk("fwd_valid",  64'(fwd_valid),             64'(e_fv));
    chk("fwd_reg",    64'(fwd_reg),               64'(e_fr));
    chk("fwd_data",   64'(fwd_data),              64'(e_fd));
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic ordy, input word_t w);
    startin   = rst;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    cur_w     = w;
  endtask

  // Advance one clock edge and update the scoreboard; returns at edge+1.
  task automatic tick();
    bit    do_pop;
    bit    do_acc;
    word_t popped;
    do_pop = (q.size() != 0) && out_ready;
    do_acc = in_valid && (q.size() < 2);
    @(posedge clock);
    if (startin) begin
      q.delete();
      held = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (do_pop) begin
        popped = q.pop_front();
        $display("pop  reg=%0d alu=%h rd=%h wb=%b", popped.rg, popped.alu, popped.rd, popped.wb);
      end
      if (do_acc) q.push_back(cur_w);
    end
    if (q.size() != 0) held = q[0];
    #1;
  endtask

  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic ordy, input word_t w);
    drive(rst, fl, iv, ordy, w);
    @(negedge clock);
    check_outputs();
    tick();
  endtask

  initial begin
    // Streaming: 4 words back to back, then drain.
    for (int i = 0; i < 4; i++)
      vecs[i] = '{1'b1, 1'b1, mk(32'h10 + 32'(i), 5'(i + 1), 2'b10, 32'h100 + 32'(i)),
                  (i > 0), 1'b1};
    vecs[4]  = '{1'b0, 1'b1, mk(0, 0, 0, 0), 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, mk(0, 0, 0, 0), 1'b0, 1'b1};
    // Stall with continuous in_valid, then release.
    vecs[6]  = '{1'b1, 1'b0, mk(32'h20, 5'd8,  2'b10, 32'h200), 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, mk(32'h21, 5'd9,  2'b10, 32'h201), 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, mk(32'h22, 5'd10, 2'b10, 32'h202), 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, mk(32'h22, 5'd10, 2'b10, 32'h202), 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, mk(32'h22, 5'd10, 2'b10, 32'h202), 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, mk(32'h22, 5'd10, 2'b10, 32'h202), 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, mk(0, 0, 0, 0), 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, mk(0, 0, 0, 0), 1'b0, 1'b1};

    held = '0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, mk(32'hFFFF, 5'd3, 2'b11, 32'hFFFF));
    repeat (2) @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0));
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_alu",       64'(alu_result_output), 64'd0);
    chk("reset_wb",        64'(WB_output), 64'd0);

    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'b0, vecs[i].iv, vecs[i].ordy, vecs[i].w);
      @(negedge clock);
      check_outputs();
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].exp_ir));
      tick();
    end

    // Flush with both entries full; the word offered in the flush cycle is lost.
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h30, 5'd11, 2'b10, 32'h300));
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h31, 5'd12, 2'b10, 32'h301));
    step(1'b0, 1'b1, 1'b1, 1'b0, mk(32'h32, 5'd13, 2'b10, 32'h302));
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    // Flush while in_ready=1: the offered word must be dropped.
    step(1'b0, 1'b1, 1'b1, 1'b1, mk(32'h33, 5'd14, 2'b10, 32'h303));
    chk("flush_drop_valid", 64'(out_valid), 64'd0);
    chk("flush_keep_alu",   64'(alu_result_output), 64'h30);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0));
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0));

    // Reset in the middle of a stall with M and S full.
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h40, 5'd15, 2'b11, 32'h400));
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h41, 5'd16, 2'b11, 32'h401));
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'h42, 5'd17, 2'b11, 32'h402));
    chk("rst_stall_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_in_ready",  64'(in_ready),  64'd1);
    chk("rst_stall_alu",       64'(alu_result_output), 64'd0);
    chk("rst_stall_rd",        64'(read_data_output), 64'd0);
    chk("rst_stall_reg",       64'(write_register_output), 64'd0);
    chk("rst_stall_wb",        64'(WB_output), 64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0));

    // Forwarding: load result, ALU result, then register 0.
    step(1'b0, 1'b0, 1'b1, 1'b1, mk(32'h4, 5'd7, 2'b11, 32'hDEAD_BEEF));
`ifdef MEM_WB_FWD_EN
    chk("fwd_load_valid", 64'(fwd_valid), 64'd1);
    chk("fwd_load_reg",   64'(fwd_reg),   64'd7);
    chk("fwd_load_data",  64'(fwd_data),  64'hDEAD_BEEF);
`else
    chk("fwd_off_valid", 64'(fwd_valid), 64'd0);
    chk("fwd_off_data",  64'(fwd_data),  64'd0);
`endif
    step(1'b0, 1'b0, 1'b1, 1'b1, mk(32'h4, 5'd7, 2'b10, 32'hDEAD_BEEF));
`ifdef MEM_WB_FWD_EN
    chk("fwd_alu_data", 64'(fwd_data), 64'h4);
`endif
    step(1'b0, 1'b0, 1'b1, 1'b1, mk(32'h4, 5'd0, 2'b11, 32'hDEAD_BEEF));
    chk("fwd_r0_valid", 64'(fwd_valid), 64'd0);

    // Bubble: pop without refill keeps payload but reports no write.
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0));
    chk("bubble_out_valid", 64'(out_valid), 64'd0);
    chk("bubble_wb",        64'(WB_output), 64'd0);
    chk("bubble_alu",       64'(alu_result_output), 64'h4);
    chk("bubble_rd",        64'(read_data_output), 64'hDEAD_BEEF);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
